// File: rtl/button_debounce_edge.sv
// Button/sensor conditioner: synchronizes one raw asynchronous line, debounces it
// into a clean level, and emits single-cycle rise, fall and long-hold pulses.
module button_debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic signal_in,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic held
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam bit HOLD_EN = (HOLD_CYCLES > 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  // Hold counter advances by one and sticks at the terminal count so it never wraps.
  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_MAX) ? v : v + HOLD_ONE;
  endfunction

  // Debounce counter advance; the FSM commits before the count could reach its width limit.
  function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
    return v + DB_ONE;
  endfunction

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_lvl;

  state_t            state, state_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic              stable_d, rise_d, fall_d, held_d;

  assign sync_lvl = sync_pipe[SYNC_STAGES-1];

  // Synchronizer chain: raw input enters bit 0, the settled level leaves the top bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], signal_in};
    end
  end

  // Debounce FSM next-state: a change commits only after DEBOUNCE_CYCLES consecutive
  // samples of the new level; one sample of the old level abandons the attempt.
  always_comb begin
    state_d  = state;
    db_cnt_d = db_cnt;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    case (state)
      LOW: begin
        if (sync_lvl) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = HIGH;
            db_cnt_d = '0;
            rise_d   = 1'b1;
          end else begin
            state_d  = CHK_HIGH;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CHK_HIGH: begin
        if (!sync_lvl) begin
          state_d  = LOW;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d  = HIGH;
          db_cnt_d = '0;
          rise_d   = 1'b1;
        end else begin
          db_cnt_d = db_inc(db_cnt);
        end
      end
      HIGH: begin
        if (!sync_lvl) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d  = LOW;
            db_cnt_d = '0;
            fall_d   = 1'b1;
          end else begin
            state_d  = CHK_LOW;
            db_cnt_d = DB_ONE;
          end
        end
      end
      CHK_LOW: begin
        if (sync_lvl) begin
          state_d  = HIGH;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d  = LOW;
          db_cnt_d = '0;
          fall_d   = 1'b1;
        end else begin
          db_cnt_d = db_inc(db_cnt);
        end
      end
      default: begin
        state_d  = LOW;
        db_cnt_d = '0;
      end
    endcase
    stable_d = (state_d == HIGH) || (state_d == CHK_LOW);
  end

  // Hold tracking: counts cycles of stable=1 since rise; a fall on the same cycle wins.
  always_comb begin
    hold_cnt_d = hold_cnt;
    held_d     = 1'b0;
    if (rise_d || fall_d) begin
      hold_cnt_d = '0;
    end else if (stable) begin
      hold_cnt_d = hold_sat_inc(hold_cnt);
      held_d     = HOLD_EN && (hold_cnt == HOLD_LAST);
    end
  end

  // State, counters and registered outputs; reset aborts any pending change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOW;
      db_cnt   <= '0;
      hold_cnt <= '0;
      stable   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_d;
      db_cnt   <= db_cnt_d;
      hold_cnt <= hold_cnt_d;
      stable   <= stable_d;
      rise     <= rise_d;
      fall     <= fall_d;
      held     <= held_d;
    end
  end

endmodule
